// File: rtl/oled_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module   : oled_pattern_loader
// Purpose  : Producer side of the NEXT_PATTERN / PATTERN_VALID handshake for
//            the OLED stimulation FSM. It pulls WORD_W-bit words from a
//            host-filled FIFO (1-cycle read latency) into a shadow buffer.
//            It presents a stable MASK_W-bit dis_led mask and swaps in the
//            prefetched shadow on request.
// Ports    : clk           - system clock, rising edge
//            rst           - asynchronous active-low reset (0 = reset)
//            en            - loader enable, gates new FIFO reads
//            fifo_dout     - FIFO read data, valid the cycle after fifo_rd_en
//            fifo_empty    - FIFO empty flag
//            fifo_rd_en    - FIFO read strobe (combinational)
//            next_pattern  - 1-cycle request pulse from the stim FSM
//            dis_led_mask  - active pattern (registered)
//            pattern_valid - dis_led_mask holds a complete pattern
//            shadow_full   - shadow holds a complete prefetched pattern
//            pattern_count - number of patterns made active (wraps)
//            underrun      - sticky: request arrived with no complete shadow
//            clr_underrun  - synchronous clear of underrun
// Revision : 1.0 - initial release
// ============================================================================
module oled_pattern_loader #(
   parameter int WORD_W = 32,
   parameter int MASK_W = 1024,            // integer multiple of WORD_W
   parameter int NWORDS = MASK_W / WORD_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [WORD_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic              next_pattern,
   output logic [MASK_W-1:0] dis_led_mask,
   output logic              pattern_valid,
   output logic              shadow_full,
   output logic [CNT_W-1:0]  pattern_count,
   output logic              underrun,
   input  logic              clr_underrun
);

   // idx addresses a word slot (0..NWORDS-1); issued counts outstanding
   // reads of the current pattern and must be able to hold NWORDS itself.
   localparam int                 C_IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int                 C_ISS_W    = $clog2(NWORDS + 1);
   localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NWORDS - 1);
   localparam logic [C_ISS_W-1:0] C_NWORDS   = C_ISS_W'(NWORDS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                        r_state;
   state_t                        w_state_next;

   // Word i of a pattern occupies mask bits [WORD_W*i +: WORD_W], which is
   // exactly the layout of this packed array.
   logic [NWORDS-1:0][WORD_W-1:0] r_shadow;
   logic [NWORDS-1:0][WORD_W-1:0] w_shadow_merged;
   logic [MASK_W-1:0]             r_active;
   logic [C_IDX_W-1:0]            r_idx;
   logic [C_ISS_W-1:0]            r_issued;
   logic                          r_rd_pending;
   logic                          r_pattern_valid;
   logic                          r_shadow_full;
   logic                          r_underrun;
   logic [CNT_W-1:0]              r_pattern_count;

   logic                          w_rd_en;
   logic                          w_last_word;
   logic                          w_swap;
   logic                          w_swap_possible;
   logic                          w_underrun_set;

   // The final word of the pattern is being written this cycle.
   assign w_last_word = r_rd_pending && (r_idx == C_LAST_IDX);

   // A request is served if a complete shadow exists now (FULL) or is being
   // completed this cycle. Anything else, or a request while the active
   // mask is not valid, counts as an underrun.
   assign w_swap_possible = (r_state == ST_FULL) || w_last_word;
   assign w_underrun_set  = next_pattern && (!w_swap_possible || !r_pattern_valid);

   // Shadow as it will look after this cycle's write. A swap coinciding with
   // the last word must include that word, so the swap source is taken from
   // here rather than from r_shadow.
   always_comb begin
      w_shadow_merged = r_shadow;
      if (r_rd_pending) begin
         w_shadow_merged[r_idx] = fifo_dout;
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM: next state, read strobe and swap decision
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_rd_en      = 1'b0;
      w_swap       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (en) begin
               w_state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            w_rd_en = en && !fifo_empty && (r_issued < C_NWORDS);
            if (w_last_word) begin
               if (next_pattern) begin
                  // Completed shadow goes straight to the active register;
                  // keep fetching the following pattern.
                  w_swap = 1'b1;
               end else begin
                  w_state_next = ST_FULL;
               end
            end
         end
         ST_FULL: begin
            // Auto-swap when nothing valid is shown (initial fill or recovery
            // after an underrun); otherwise wait for the stim FSM to ask.
            if (!r_pattern_valid || next_pattern) begin
               w_swap       = 1'b1;
               w_state_next = ST_FETCH;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Fetch datapath: read tracking and shadow assembly
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_pending  <= 1'b0;
         r_issued      <= '0;
         r_idx         <= '0;
         r_shadow      <= '0;
         r_shadow_full <= 1'b0;
      end else begin
         r_rd_pending <= w_rd_en;

         if (w_rd_en) begin
            r_issued <= r_issued + 1'b1;
         end

         // Capture is driven only by rd_pending, so a word already in flight
         // is kept even if en drops or the FIFO goes empty meanwhile.
         if (r_rd_pending) begin
            r_shadow[r_idx] <= fifo_dout;
            if (w_last_word) begin
               r_idx    <= '0;
               r_issued <= '0;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end

         if (w_swap) begin
            r_shadow_full <= 1'b0;
         end else if (w_last_word) begin
            r_shadow_full <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Presentation side: active mask, valid flag, counter, underrun
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_active        <= '0;
         r_pattern_valid <= 1'b0;
         r_pattern_count <= '0;
         r_underrun      <= 1'b0;
      end else begin
         if (w_swap) begin
            r_active        <= w_shadow_merged;
            r_pattern_valid <= 1'b1;
            r_pattern_count <= r_pattern_count + 1'b1;
         end else if (w_underrun_set) begin
            // The old mask stays on the outputs but is flagged stale.
            r_pattern_valid <= 1'b0;
         end

         // A new underrun event wins over a simultaneous clear.
         if (w_underrun_set) begin
            r_underrun <= 1'b1;
         end else if (clr_underrun) begin
            r_underrun <= 1'b0;
         end
      end
   end

   assign fifo_rd_en    = w_rd_en;
   assign dis_led_mask  = r_active;
   assign pattern_valid = r_pattern_valid;
   assign shadow_full   = r_shadow_full;
   assign pattern_count = r_pattern_count;
   assign underrun      = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_oled_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_pattern_loader
// Purpose  : Self-checking bench for oled_pattern_loader. A queue-based FIFO
//            with 1-cycle read latency feeds the DUT. Each pattern is a list
//            of random words. The expected mask is those words concatenated,
//            word 0 at the LSBs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oled_pattern_loader;

   localparam int WORD_W = 32;
   localparam int MASK_W = 1024;
   localparam int NWORDS = MASK_W / WORD_W;
   localparam int CNT_W  = 16;

   typedef logic [WORD_W-1:0] pat_t [NWORDS];

   logic              clk;
   logic              rst;
   logic              en;
   logic [WORD_W-1:0] fifo_dout;
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic              next_pattern;
   logic [MASK_W-1:0] dis_led_mask;
   logic              pattern_valid;
   logic              shadow_full;
   logic [CNT_W-1:0]  pattern_count;
   logic              underrun;
   logic              clr_underrun;

   int                checks;
   int                errors;
   int                rd_violations;
   int                pop_errors;
   logic [WORD_W-1:0] fifo_q[$];
   bit                hold_empty;
   bit                last_rd;

   oled_pattern_loader #(
      .WORD_W (WORD_W),
      .MASK_W (MASK_W),
      .NWORDS (NWORDS),
      .CNT_W  (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .fifo_dout     (fifo_dout),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .next_pattern  (next_pattern),
      .dis_led_mask  (dis_led_mask),
      .pattern_valid (pattern_valid),
      .shadow_full   (shadow_full),
      .pattern_count (pattern_count),
      .underrun      (underrun),
      .clr_underrun  (clr_underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------- model
   function automatic logic [MASK_W-1:0] words_to_mask(input pat_t p);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int i = 0; i < NWORDS; i++) m[WORD_W*i +: WORD_W] = p[i];
      return m;
   endfunction

   function automatic int first_diff(input logic [MASK_W-1:0] a, input logic [MASK_W-1:0] b);
      for (int i = 0; i < NWORDS; i++)
         if (a[WORD_W*i +: WORD_W] !== b[WORD_W*i +: WORD_W]) return i;
      return 0;
   endfunction

   function automatic pat_t rand_pat();
      pat_t p;
      for (int i = 0; i < NWORDS; i++) p[i] = $urandom;
      return p;
   endfunction

   task automatic push_words(input pat_t p, input int from, input int upto);
      for (int i = from; i <= upto; i++) fifo_q.push_back(p[i]);
   endtask

   // One clock: settle inputs, police fifo_rd_en, then model the FIFO read.
   // On return the time is just after the edge, with everything settled.
   task automatic cycle();
      bit rd_now;
      fifo_empty = hold_empty || (fifo_q.size() == 0);
      #1;
      if (fifo_rd_en && (fifo_empty || !en)) rd_violations++;
      rd_now = fifo_rd_en;
      @(posedge clk);
      #1;
      if (rd_now) begin
         if (fifo_q.size() == 0) pop_errors++;
         else fifo_dout = fifo_q.pop_front();
      end
      last_rd    = rd_now;
      fifo_empty = hold_empty || (fifo_q.size() == 0);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      en           = 1'b0;
      next_pattern = 1'b0;
      clr_underrun = 1'b0;
      hold_empty   = 1'b0;
      fifo_dout    = '0;
      fifo_q.delete();
      repeat (2) cycle();
      rst = 1'b1;
      cycle();
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      for (int c = 0; c < budget && !pattern_valid; c++) cycle();
      ok = pattern_valid;
   endtask

   task automatic wait_shadow(input int budget, output bit ok);
      for (int c = 0; c < budget && !shadow_full; c++) cycle();
      ok = shadow_full;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b0; en = 1'b0; next_pattern = 1'b0; clr_underrun = 1'b0;
      hold_empty = 1'b0; fifo_dout = '0; fifo_empty = 1'b1;
      #2;
      checks++; if (dis_led_mask !== '0) begin errors++; $display("FAIL reset_mask: got nonzero, expected 0"); end
      checks++; if (pattern_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pattern_valid); end
      checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL reset_shadow_full: got %b expected 0", shadow_full); end
      checks++; if (pattern_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", pattern_count); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
      repeat (2) cycle();
      rst = 1'b1;
      fifo_q.push_back(32'h1234_5678);
      repeat (2) cycle();
      checks++; if (last_rd !== 1'b0) begin errors++; $display("FAIL idle_no_read: got rd %b with en=0, expected 0", last_rd); end
   endtask

   task automatic test_initial_fill();
      pat_t p;
      int   n;
      bit   started;
      do_reset();
      for (int i = 0; i < NWORDS; i++) p[i] = WORD_W'(i);
      push_words(p, 0, NWORDS - 1);
      en = 1'b1;
      n = 0; started = 0;
      for (int c = 0; c < 100; c++) begin
         cycle();
         if (last_rd) begin n++; started = 1; end
         else if (started) break;
      end
      // now in cycle L+2
      checks++; if (n !== NWORDS) begin errors++; $display("FAIL fill_rd_burst: got %0d consecutive reads expected %0d", n, NWORDS); end
      checks++; if (shadow_full !== 1'b1 || pattern_valid !== 1'b0) begin errors++;
         $display("FAIL fill_L2_flags: got shadow_full=%b valid=%b expected 1/0", shadow_full, pattern_valid); end
      cycle();
      checks++; if (pattern_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b expected 1", pattern_valid); end
      checks++; if (dis_led_mask[31:0] !== 32'h0) begin errors++; $display("FAIL fill_word0: got %h expected 00000000", dis_led_mask[31:0]); end
      checks++; if (dis_led_mask[1023:992] !== 32'h1F) begin errors++; $display("FAIL fill_word31: got %h expected 0000001f", dis_led_mask[1023:992]); end
      checks++; if (dis_led_mask !== words_to_mask(p)) begin errors++;
         $display("FAIL fill_mask: word %0d got %h expected %h", first_diff(dis_led_mask, words_to_mask(p)),
                  dis_led_mask[WORD_W*first_diff(dis_led_mask, words_to_mask(p)) +: WORD_W], p[first_diff(dis_led_mask, words_to_mask(p))]); end
      checks++; if (pattern_count !== CNT_W'(1)) begin errors++; $display("FAIL fill_count: got %0d expected 1", pattern_count); end
      checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL fill_shadow_cleared: got %b expected 0", shadow_full); end
      fifo_q.push_back($urandom);
      n = 0;
      repeat (3) begin cycle(); if (last_rd) n++; end
      checks++; if (n !== 1) begin errors++; $display("FAIL second_fetch_start: got %0d reads expected 1", n); end
   endtask

   task automatic test_swap();
      pat_t a, b, c;
      bit   ok;
      int   n;
      do_reset();
      a = rand_pat(); c = rand_pat();
      for (int i = 0; i < NWORDS; i++) b[i] = '1;
      push_words(a, 0, NWORDS - 1);
      push_words(b, 0, NWORDS - 1);
      en = 1'b1;
      wait_valid(100, ok);
      checks++; if (!ok || dis_led_mask !== words_to_mask(a)) begin errors++; $display("FAIL swap_first: valid=%b mask word0 %h expected %h", ok, dis_led_mask[31:0], a[0]); end
      wait_shadow(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL swap_prefetch_timeout: shadow_full=%b expected 1", shadow_full); end
      checks++; if (dis_led_mask !== words_to_mask(a)) begin errors++; $display("FAIL swap_hold: mask word0 %h expected %h", dis_led_mask[31:0], a[0]); end
      push_words(c, 0, NWORDS - 1);
      n = 0;
      repeat (5) begin cycle(); if (last_rd) n++; end
      checks++; if (n !== 0) begin errors++; $display("FAIL full_no_read: got %0d reads expected 0", n); end
      next_pattern = 1'b1;
      cycle();
      next_pattern = 1'b0;
      checks++; if (dis_led_mask !== words_to_mask(b)) begin errors++; $display("FAIL swap_mask_b: word0 %h expected %h", dis_led_mask[31:0], b[0]); end
      checks++; if (pattern_count !== CNT_W'(2)) begin errors++; $display("FAIL swap_count: got %0d expected 2", pattern_count); end
      checks++; if (shadow_full !== 1'b0 || underrun !== 1'b0) begin errors++;
         $display("FAIL swap_flags: shadow_full=%b underrun=%b expected 0/0", shadow_full, underrun); end
      wait_shadow(100, ok);
      next_pattern = 1'b1;
      cycle();
      next_pattern = 1'b0;
      checks++; if (!ok || dis_led_mask !== words_to_mask(c) || pattern_count !== CNT_W'(3)) begin errors++;
         $display("FAIL swap_mask_c: word5 %h expected %h count %0d expected 3", dis_led_mask[191:160], c[5], pattern_count); end
   endtask

   task automatic test_underrun();
      pat_t p0, p1;
      bit   ok;
      do_reset();
      p0 = rand_pat(); p1 = rand_pat();
      push_words(p0, 0, NWORDS - 1);
      en = 1'b1;
      wait_valid(100, ok);
      push_words(p1, 0, 19);
      repeat (30) cycle();
      checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL ur_partial: shadow_full=%b expected 0", shadow_full); end
      next_pattern = 1'b1;
      cycle();
      next_pattern = 1'b0;
      checks++; if (underrun !== 1'b1 || pattern_valid !== 1'b0) begin errors++;
         $display("FAIL ur_flags: underrun=%b valid=%b expected 1/0", underrun, pattern_valid); end
      checks++; if (dis_led_mask !== words_to_mask(p0) || pattern_count !== CNT_W'(1)) begin errors++;
         $display("FAIL ur_hold: word0 %h expected %h count %0d expected 1", dis_led_mask[31:0], p0[0], pattern_count); end
      push_words(p1, 20, NWORDS - 1);
      wait_valid(100, ok);
      checks++; if (!ok || dis_led_mask !== words_to_mask(p1) || pattern_count !== CNT_W'(2)) begin errors++;
         $display("FAIL ur_recover: valid=%b word20 %h expected %h count %0d expected 2", ok, dis_led_mask[671:640], p1[20], pattern_count); end
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b expected 1", underrun); end
      clr_underrun = 1'b1;
      cycle();
      clr_underrun = 1'b0;
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b expected 0", underrun); end
      next_pattern = 1'b1; clr_underrun = 1'b1;
      cycle();
      next_pattern = 1'b0; clr_underrun = 1'b0;
      checks++; if (underrun !== 1'b1 || dis_led_mask !== words_to_mask(p1)) begin errors++;
         $display("FAIL ur_set_beats_clr: underrun=%b expected 1, word0 %h expected %h", underrun, dis_led_mask[31:0], p1[0]); end
   endtask

   task automatic test_simultaneous();
      pat_t p0, p1, p2;
      bit   ok;
      int   n;
      do_reset();
      p0 = rand_pat(); p1 = rand_pat(); p2 = rand_pat();
      push_words(p0, 0, NWORDS - 1);
      en = 1'b1;
      wait_valid(100, ok);
      push_words(p1, 0, NWORDS - 1);
      n = 0;
      for (int c = 0; c < 100 && n < NWORDS; c++) begin
         cycle();
         if (last_rd) n++;
      end
      // the last word is in flight and gets captured during this cycle
      next_pattern = 1'b1;
      cycle();
      next_pattern = 1'b0;
      checks++; if (dis_led_mask !== words_to_mask(p1)) begin errors++;
         $display("FAIL sim_mask: word31 %h expected %h", dis_led_mask[1023:992], p1[31]); end
      checks++; if (underrun !== 1'b0 || pattern_valid !== 1'b1 || shadow_full !== 1'b0 || pattern_count !== CNT_W'(2)) begin errors++;
         $display("FAIL sim_flags: underrun=%b valid=%b shadow_full=%b count=%0d expected 0/1/0/2", underrun, pattern_valid, shadow_full, pattern_count); end
      push_words(p2, 0, NWORDS - 1);
      wait_shadow(100, ok);
      next_pattern = 1'b1;
      cycle();
      next_pattern = 1'b0;
      checks++; if (!ok || dis_led_mask !== words_to_mask(p2) || pattern_count !== CNT_W'(3)) begin errors++;
         $display("FAIL sim_next: shadow=%b word0 %h expected %h count %0d expected 3", ok, dis_led_mask[31:0], p2[0], pattern_count); end
   endtask

   task automatic test_gaps();
      pat_t p;
      do_reset();
      p = rand_pat();
      push_words(p, 0, NWORDS - 1);
      for (int c = 0; c < 300 && !pattern_valid; c++) begin
         hold_empty = ((c % 2) == 1);
         en         = !(c >= 15 && c < 20);
         cycle();
      end
      hold_empty = 1'b0;
      en         = 1'b1;
      checks++; if (pattern_valid !== 1'b1 || dis_led_mask !== words_to_mask(p)) begin errors++;
         $display("FAIL gaps_mask: valid=%b word %0d got %h expected %h", pattern_valid, first_diff(dis_led_mask, words_to_mask(p)),
                  dis_led_mask[WORD_W*first_diff(dis_led_mask, words_to_mask(p)) +: WORD_W], p[first_diff(dis_led_mask, words_to_mask(p))]); end
      checks++; if (pattern_count !== CNT_W'(1)) begin errors++; $display("FAIL gaps_count: got %0d expected 1", pattern_count); end
      checks++; if (rd_violations !== 0 || pop_errors !== 0) begin errors++;
         $display("FAIL rd_en_legality: %0d illegal strobes, %0d empty pops, expected 0/0", rd_violations, pop_errors); end
   endtask

   task automatic test_reset_midfetch();
      pat_t p0, p1, p2;
      bit   ok;
      int   n;
      do_reset();
      p0 = rand_pat(); p1 = rand_pat(); p2 = rand_pat();
      p0[0] = p0[0] | 32'h1;
      push_words(p0, 0, NWORDS - 1);
      push_words(p1, 0, NWORDS - 1);
      en = 1'b1;
      wait_valid(100, ok);
      n = 0;
      for (int c = 0; c < 100 && n < 10; c++) begin
         cycle();
         if (last_rd) n++;
      end
      cycle();
      rst = 1'b0;
      #1;
      checks++; if (dis_led_mask !== '0 || pattern_valid !== 1'b0 || pattern_count !== '0) begin errors++;
         $display("FAIL async_reset_a: word0 %h valid=%b count=%0d expected 0/0/0", dis_led_mask[31:0], pattern_valid, pattern_count); end
      checks++; if (shadow_full !== 1'b0 || underrun !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++;
         $display("FAIL async_reset_b: shadow_full=%b underrun=%b rd_en=%b expected 0/0/0", shadow_full, underrun, fifo_rd_en); end
      fifo_q.delete();
      repeat (2) cycle();
      rst = 1'b1;
      push_words(p2, 0, NWORDS - 1);
      n = 0;
      for (int c = 0; c < 150 && !pattern_valid; c++) begin
         cycle();
         if (last_rd) n++;
      end
      checks++; if (pattern_valid !== 1'b1 || n !== NWORDS) begin errors++;
         $display("FAIL refetch_reads: valid=%b after %0d reads expected 1 after %0d", pattern_valid, n, NWORDS); end
      checks++; if (dis_led_mask !== words_to_mask(p2) || pattern_count !== CNT_W'(1)) begin errors++;
         $display("FAIL refetch_mask: word0 %h expected %h count %0d expected 1", dis_led_mask[31:0], p2[0], pattern_count); end
   endtask

   initial begin
      checks = 0; errors = 0; rd_violations = 0; pop_errors = 0;
      last_rd = 1'b0;
      test_reset();
      test_initial_fill();
      test_swap();
      test_underrun();
      test_simultaneous();
      test_gaps();
      test_reset_midfetch();
      checks++; if (rd_violations !== 0 || pop_errors !== 0) begin errors++;
         $display("FAIL rd_en_legality_all: %0d illegal strobes, %0d empty pops, expected 0/0", rd_violations, pop_errors); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
